// File: rtl/twofish_q_pipe.sv
// Twofish q0/q1 byte permutation, LANES bytes per word, two-stage valid/ready pipeline.
// Each stage performs one nibble mixing round followed by a pair of 4-bit table lookups.
module twofish_q_pipe #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    input  logic [LANES-1:0]   in_sel,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*LANES-1:0] out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);

    typedef logic [3:0] nib_t;

    localparam nib_t Q0_T0 [16] = '{4'h8, 4'h1, 4'h7, 4'hD, 4'h6, 4'hF, 4'h3, 4'h2,
                                    4'h0, 4'hB, 4'h5, 4'h9, 4'hE, 4'hC, 4'hA, 4'h4};
    localparam nib_t Q0_T1 [16] = '{4'hE, 4'hC, 4'hB, 4'h8, 4'h1, 4'h2, 4'h3, 4'h5,
                                    4'hF, 4'h4, 4'hA, 4'h6, 4'h7, 4'h0, 4'h9, 4'hD};
    localparam nib_t Q0_T2 [16] = '{4'hB, 4'hA, 4'h5, 4'hE, 4'h6, 4'hD, 4'h9, 4'h0,
                                    4'hC, 4'h8, 4'hF, 4'h3, 4'h2, 4'h4, 4'h7, 4'h1};
    localparam nib_t Q0_T3 [16] = '{4'hD, 4'h7, 4'hF, 4'h4, 4'h1, 4'h2, 4'h6, 4'hE,
                                    4'h9, 4'hB, 4'h3, 4'h0, 4'h8, 4'h5, 4'hC, 4'hA};
    localparam nib_t Q1_T0 [16] = '{4'h2, 4'h8, 4'hB, 4'hD, 4'hF, 4'h7, 4'h6, 4'hE,
                                    4'h3, 4'h1, 4'h9, 4'h4, 4'h0, 4'hA, 4'hC, 4'h5};
    localparam nib_t Q1_T1 [16] = '{4'h1, 4'hE, 4'h2, 4'hB, 4'h4, 4'hC, 4'h3, 4'h7,
                                    4'h6, 4'hD, 4'hA, 4'h5, 4'hF, 4'h9, 4'h0, 4'h8};
    localparam nib_t Q1_T2 [16] = '{4'h4, 4'hC, 4'h7, 4'h5, 4'h1, 4'h6, 4'h9, 4'hA,
                                    4'h0, 4'hE, 4'hD, 4'h8, 4'h2, 4'hB, 4'h3, 4'hF};
    localparam nib_t Q1_T3 [16] = '{4'hB, 4'h9, 4'h5, 4'h1, 4'hC, 4'h3, 4'hD, 4'hE,
                                    4'h6, 4'h4, 4'h7, 4'hF, 4'h2, 4'h0, 4'h8, 4'hA};

    function automatic nib_t ror4(input nib_t v);
        return {v[0], v[3:1]};
    endfunction

    function automatic nib_t shl3(input nib_t v);
        return {v[0], 3'b000};
    endfunction

    // Returns {a2, b2}: a in the high nibble of the intermediate byte.
    function automatic logic [7:0] round1(input logic [7:0] x, input logic sel);
        nib_t a, b, ma, mb;
        a  = x[7:4];
        b  = x[3:0];
        ma = a ^ b;
        mb = a ^ ror4(b) ^ shl3(a);
        if (sel)
            return {Q1_T0[ma], Q1_T1[mb]};
        else
            return {Q0_T0[ma], Q0_T1[mb]};
    endfunction

    // Final byte puts b4 in the high nibble, a4 in the low nibble.
    function automatic logic [7:0] round2(input logic [7:0] x, input logic sel);
        nib_t a, b, ma, mb;
        a  = x[7:4];
        b  = x[3:0];
        ma = a ^ b;
        mb = a ^ ror4(b) ^ shl3(a);
        if (sel)
            return {Q1_T3[mb], Q1_T2[ma]};
        else
            return {Q0_T3[mb], Q0_T2[ma]};
    endfunction

    logic               v1, v2;
    logic               adv1, adv2;
    logic [8*LANES-1:0] s1_ab;
    logic [LANES-1:0]   s1_sel;
    logic [TAG_W-1:0]   s1_tag;
    logic [8*LANES-1:0] s1_next, s2_next;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;
    assign busy      = v1 || v2;

    always_comb begin
        s1_next = '0;
        s2_next = '0;
        for (int i = 0; i < LANES; i++) begin
            s1_next[8*i +: 8] = round1(in_data[8*i +: 8], in_sel[i]);
            s2_next[8*i +: 8] = round2(s1_ab[8*i +: 8], s1_sel[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            s1_ab    <= '0;
            s1_sel   <= '0;
            s1_tag   <= '0;
            out_data <= '0;
            out_tag  <= '0;
        end else begin
            if (adv2) begin
                v2       <= v1;
                out_data <= s2_next;
                out_tag  <= s1_tag;
            end
            if (adv1) begin
                v1     <= in_valid;
                s1_ab  <= s1_next;
                s1_sel <= in_sel;
                s1_tag <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_twofish_q_pipe.sv
// Directed and randomised checks of the twofish_q_pipe q-permutation pipeline.
module tb_twofish_q_pipe;

    localparam int LANES = 4;
    localparam int TAG_W = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [8*LANES-1:0] in_data;
    logic [LANES-1:0]   in_sel;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [8*LANES-1:0] out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;

    int cmp_n = 0;
    int err_n = 0;

    twofish_q_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sel(in_sel), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference q permutation, two rounds of mix + lookup over per-mode tables.
    function automatic logic [7:0] q_model(input logic sel, input logic [7:0] x);
        logic [3:0] t [4][16];
        logic [3:0] a, b, p, q;
        if (!sel)
            t = '{'{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4},
                  '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD},
                  '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1},
                  '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA}};
        else
            t = '{'{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5},
                  '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8},
                  '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF},
                  '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA}};
        a = x[7:4];
        b = x[3:0];
        for (int r = 0; r < 2; r++) begin
            p = a ^ b;
            q = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
            a = t[2*r][p];
            b = t[2*r+1][q];
        end
        return {b, a};
    endfunction

    function automatic logic [31:0] word_model(input logic [3:0] sel, input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = q_model(sel[i], d[8*i +: 8]);
        return r;
    endfunction

    task automatic test_reset();
        #1;
        cmp_n++; if (out_valid !== 1'b0) begin err_n++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        cmp_n++; if (out_data !== 32'h0) begin err_n++; $display("FAIL reset_out_data got=%h want=00000000", out_data); end
        cmp_n++; if (out_tag !== 4'h0) begin err_n++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
        cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL reset_busy got=%b want=0", busy); end
        cmp_n++; if (in_ready !== 1'b1) begin err_n++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    // One word through an idle pipe: checks latency 2 and the hand-computed result.
    task automatic test_vector(input string name, input logic [31:0] d, input logic [3:0] sel,
                               input logic [3:0] tag, input logic [31:0] exp_d);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sel = sel; in_tag = tag; out_ready = 1'b1;
        #1;
        cmp_n++; if (in_ready !== 1'b1) begin err_n++; $display("FAIL %s_in_ready got=%b want=1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0; in_data = '1; in_sel = '1; in_tag = '1;
        #1;
        cmp_n++; if (out_valid !== 1'b0) begin err_n++; $display("FAIL %s_early_valid got=%b want=0", name, out_valid); end
        @(negedge clk);
        #1;
        cmp_n++; if (out_valid !== 1'b1) begin err_n++; $display("FAIL %s_valid got=%b want=1", name, out_valid); end
        cmp_n++; if (out_data !== exp_d) begin err_n++; $display("FAIL %s_data got=%h want=%h", name, out_data, exp_d); end
        cmp_n++; if (out_tag !== tag) begin err_n++; $display("FAIL %s_tag got=%h want=%h", name, out_tag, tag); end
        @(negedge clk);
        #1;
        cmp_n++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            err_n++; $display("FAIL %s_drain got valid=%b busy=%b want 0 0", name, out_valid, busy);
        end
    endtask

    task automatic test_exhaustive(input logic mode);
        logic [255:0] seen;
        logic [31:0]  d, exp_d;
        logic [7:0]   k;
        int           distinct;
        seen = '0;
        for (int c = 0; c < 258; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c < 256) begin
                k = 8'(c);
                in_valid = 1'b1;
                in_data  = {k ^ 8'hC9, k ^ 8'h76, k ^ 8'h3B, k};
                in_sel   = {4{mode}};
                in_tag   = 4'(c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 2) begin
                k = 8'(c - 2);
                d = {k ^ 8'hC9, k ^ 8'h76, k ^ 8'h3B, k};
                exp_d = word_model({4{mode}}, d);
                cmp_n++;
                if (out_valid !== 1'b1 || out_data !== exp_d || out_tag !== 4'(c - 2)) begin
                    err_n++;
                    if (err_n < 20) $display("FAIL exh_mode%0d_byte%0d got v=%b d=%h t=%h want v=1 d=%h t=%h",
                                             mode, c - 2, out_valid, out_data, out_tag, exp_d, 4'(c - 2));
                end
                seen[out_data[7:0]] = 1'b1;
            end
        end
        distinct = $countones(seen);
        cmp_n++;
        if (distinct != 256) begin err_n++; $display("FAIL exh_bijection_mode%0d got=%0d want=256", mode, distinct); end
    endtask

    // Hand-scheduled stalls: lone stalled v2 still accepts, full pipe blocks, order kept.
    task automatic test_stall();
        logic [31:0] wa, wb, wc;
        wa = 32'h01234567; wb = 32'h89ABCDEF; wc = 32'hDEADBEEF;
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = wa; in_sel = 4'b0011; in_tag = 4'h1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        cmp_n++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
            err_n++; $display("FAIL stall_v2_only got valid=%b ready=%b want 1 1", out_valid, in_ready);
        end
        in_valid = 1'b1; in_data = wb; in_sel = 4'b1010; in_tag = 4'h2;
        @(negedge clk);
        in_data = wc; in_sel = 4'b0110; in_tag = 4'h3;
        #1;
        cmp_n++; if (in_ready !== 1'b0) begin err_n++; $display("FAIL stall_full_ready got=%b want=0", in_ready); end
        cmp_n++; if (out_data !== word_model(4'b0011, wa) || out_tag !== 4'h1) begin
            err_n++; $display("FAIL stall_hold1 got=%h/%h want=%h/1", out_data, out_tag, word_model(4'b0011, wa));
        end
        @(negedge clk);
        #1;
        cmp_n++; if (out_data !== word_model(4'b0011, wa) || in_ready !== 1'b0) begin
            err_n++; $display("FAIL stall_hold2 got=%h ready=%b want=%h ready=0", out_data, in_ready, word_model(4'b0011, wa));
        end
        out_ready = 1'b1;
        #1;
        cmp_n++; if (in_ready !== 1'b1) begin err_n++; $display("FAIL stall_release_ready got=%b want=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        cmp_n++; if (out_valid !== 1'b1 || out_data !== word_model(4'b1010, wb) || out_tag !== 4'h2) begin
            err_n++; $display("FAIL stall_second got=%h/%h want=%h/2", out_data, out_tag, word_model(4'b1010, wb));
        end
        @(negedge clk);
        #1;
        cmp_n++; if (out_valid !== 1'b1 || out_data !== word_model(4'b0110, wc) || out_tag !== 4'h3) begin
            err_n++; $display("FAIL stall_third got=%h/%h want=%h/3", out_data, out_tag, word_model(4'b0110, wc));
        end
        @(negedge clk);
        #1;
        cmp_n++; if (busy !== 1'b0) begin err_n++; $display("FAIL stall_drained got busy=%b want=0", busy); end
    endtask

    task automatic test_backpressure(input int n_words);
        logic [35:0] sb [$];
        logic [35:0] e;
        logic [31:0] prev_d;
        logic [3:0]  prev_t;
        logic        prev_stall, acc_in, acc_out;
        int          sent, recv, occ, cycles;
        sent = 0; recv = 0; occ = 0; cycles = 0; prev_stall = 1'b0;
        prev_d = '0; prev_t = '0;
        while ((recv < n_words) && (cycles < 40 * n_words)) begin
            @(negedge clk);
            cycles++;
            in_valid  = (sent < n_words) && ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            in_sel    = 4'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            cmp_n++;
            if (in_ready !== !(occ == 2 && !out_ready)) begin
                err_n++;
                if (err_n < 20) $display("FAIL bp_in_ready got=%b want=%b occ=%0d", in_ready, !(occ == 2 && !out_ready), occ);
            end
            cmp_n++;
            if (busy !== (occ != 0)) begin
                err_n++;
                if (err_n < 20) $display("FAIL bp_busy got=%b want=%b", busy, occ != 0);
            end
            if (prev_stall) begin
                cmp_n++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t) begin
                    err_n++;
                    if (err_n < 20) $display("FAIL bp_stable got v=%b %h/%h want v=1 %h/%h", out_valid, out_data, out_tag, prev_d, prev_t);
                end
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                cmp_n++;
                if (sb.size() == 0) begin
                    err_n++;
                    if (err_n < 20) $display("FAIL bp_extra_word got=%h want=none", out_data);
                end else begin
                    e = sb.pop_front();
                    if ({out_tag, out_data} !== e) begin
                        err_n++;
                        if (err_n < 20) $display("FAIL bp_word%0d got=%h want=%h", recv, {out_tag, out_data}, e);
                    end
                end
                recv++;
            end
            if (acc_in) begin
                sb.push_back({in_tag, word_model(in_sel, in_data)});
                sent++;
            end
            occ = occ + int'(acc_in) - int'(acc_out);
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_t = out_tag;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        cmp_n++;
        if (recv != n_words) begin err_n++; $display("FAIL bp_timeout got=%0d want=%0d", recv, n_words); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11223344; in_sel = 4'hF; in_tag = 4'h9;
        @(negedge clk);
        in_data = 32'h55667788; in_tag = 4'hA;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        cmp_n++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            err_n++; $display("FAIL rstmid_full got v=%b r=%b b=%b want 1 0 1", out_valid, in_ready, busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        cmp_n++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            err_n++; $display("FAIL rstmid_async got v=%b b=%b r=%b want 0 0 1", out_valid, busy, in_ready);
        end
        cmp_n++; if (out_data !== 32'h0 || out_tag !== 4'h0) begin
            err_n++; $display("FAIL rstmid_clear got=%h/%h want=00000000/0", out_data, out_tag);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_vector("post_reset", 32'h00000100, 4'b0000, 4'h6, 32'hA9A967A9);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; in_tag = '0; out_ready = 1'b0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_vector("q0_known", 32'h00000100, 4'b0000, 4'h3, 32'hA9A967A9);
        test_vector("q1_known", 32'h00000100, 4'b1111, 4'hC, 32'h7575F375);
        test_vector("mixed", 32'h00000000, 4'b0101, 4'h5, 32'hA975A975);
        test_exhaustive(1'b0);
        test_exhaustive(1'b1);
        test_stall();
        test_backpressure(10000);
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
